// File: rtl/tick_scheduler.sv
// Multi-channel programmable tick / slow-clock generator. Each channel divides clk_i by a
// run-time period; updates to a running channel are deferred to its next tick boundary.
module tick_scheduler #(
  parameter int unsigned NCH            = 4,
  parameter int unsigned CW             = 28,
  parameter int unsigned DEFAULT_PERIOD = 5000000,
  localparam int unsigned ChW           = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cfg_valid_i,
  output logic              cfg_ready_o,
  input  logic [ChW-1:0]    cfg_ch_i,
  input  logic [CW-1:0]     cfg_period_i,
  input  logic [NCH-1:0]    ch_en_i,
  output logic [NCH-1:0]    tick_o,
  output logic [NCH-1:0]    slow_clk_o,
  output logic              busy_o
);

  localparam logic [CW-1:0] DefPeriod = CW'(DEFAULT_PERIOD);
  localparam logic [CW-1:0] One       = CW'(1);

  typedef enum logic {StIdle, StRun} ch_state_e;

  logic [NCH-1:0][CW-1:0] active_q, active_d;
  logic [NCH-1:0][CW-1:0] shadow_q, shadow_d;
  logic [NCH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NCH-1:0]         pending_q, pending_d;
  logic [NCH-1:0]         tick_q, tick_d;
  logic [NCH-1:0]         slow_q, slow_d;

  ch_state_e      ch_state [NCH];
  logic [NCH-1:0] wr_hit;
  logic           ch_in_range;
  logic           cfg_fire;
  logic [CW-1:0]  wr_period;

  // Out-of-range channel selects are always ready so the write is consumed and dropped.
  assign ch_in_range = 32'(cfg_ch_i) < NCH;
  assign cfg_ready_o = ch_in_range ? ~pending_q[cfg_ch_i] : 1'b1;
  assign cfg_fire    = cfg_valid_i & cfg_ready_o & ch_in_range;
  assign wr_period   = (cfg_period_i == '0) ? One : cfg_period_i;

  assign tick_o     = tick_q;
  assign slow_clk_o = slow_q;
  assign busy_o     = |pending_q;

  always_comb begin
    for (int unsigned c = 0; c < NCH; c++) begin
      ch_state[c] = ch_en_i[c] ? StRun : StIdle;
      wr_hit[c]   = cfg_fire && (32'(cfg_ch_i) == c);
    end
  end

  always_comb begin
    active_d  = active_q;
    shadow_d  = shadow_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    tick_d    = tick_q;
    slow_d    = slow_q;
    for (int unsigned c = 0; c < NCH; c++) begin
      unique case (ch_state[c])
        StIdle: begin
          cnt_d[c]  = One;
          tick_d[c] = 1'b0;
          if (pending_q[c]) begin
            active_d[c]  = shadow_q[c];
            pending_d[c] = 1'b0;
          end
          // A write can only land here with pending clear, so it never races the apply.
          if (wr_hit[c]) begin
            active_d[c] = wr_period;
          end
        end
        StRun: begin
          // >= lets a period lowered below the running count still end on the next edge.
          if (cnt_q[c] >= active_q[c]) begin
            tick_d[c] = 1'b1;
            cnt_d[c]  = One;
            slow_d[c] = ~slow_q[c];
            if (pending_q[c]) begin
              active_d[c]  = shadow_q[c];
              pending_d[c] = 1'b0;
            end
          end else begin
            cnt_d[c]  = cnt_q[c] + One;
            tick_d[c] = 1'b0;
          end
          if (wr_hit[c]) begin
            shadow_d[c]  = wr_period;
            pending_d[c] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q  <= {NCH{DefPeriod}};
      shadow_q  <= {NCH{DefPeriod}};
      cnt_q     <= {NCH{One}};
      pending_q <= '0;
      tick_q    <= '0;
      slow_q    <= '0;
    end else begin
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      tick_q    <= tick_d;
      slow_q    <= slow_d;
    end
  end

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed bench for tick_scheduler: period programming, deferred updates, P=1, alignment,
// async reset, plus a 5-channel instance for out-of-range channel writes.
module tb_tick_scheduler;

  localparam int unsigned NCH  = 4;
  localparam int unsigned CW   = 16;
  localparam int unsigned DEFP = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_ni;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [1:0]     cfg_ch;
  logic [CW-1:0]  cfg_period;
  logic [NCH-1:0] ch_en;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] slow;
  logic           busy;

  logic           o_valid;
  logic           o_ready;
  logic [2:0]     o_ch;
  logic [7:0]     o_period;
  logic [4:0]     o_en;
  logic [4:0]     o_tick;
  logic [4:0]     o_slow;
  logic           o_busy;

  tick_scheduler #(
    .NCH           (NCH),
    .CW            (CW),
    .DEFAULT_PERIOD(DEFP)
  ) u_dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_ch_i    (cfg_ch),
    .cfg_period_i(cfg_period),
    .ch_en_i     (ch_en),
    .tick_o      (tick),
    .slow_clk_o  (slow),
    .busy_o      (busy)
  );

  tick_scheduler #(
    .NCH           (5),
    .CW            (8),
    .DEFAULT_PERIOD(3)
  ) u_dut5 (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cfg_valid_i (o_valid),
    .cfg_ready_o (o_ready),
    .cfg_ch_i    (o_ch),
    .cfg_period_i(o_period),
    .ch_en_i     (o_en),
    .tick_o      (o_tick),
    .slow_clk_o  (o_slow),
    .busy_o      (o_busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic        exp_slow;
  logic        exp_t;
  logic        exp_b;
  logic [3:0]  exp_v;
  int unsigned first_all;
  int unsigned per [4] = '{2, 3, 5, 7};

  initial begin
    rst_ni = 1'b0; cfg_valid = 1'b0; cfg_ch = '0; cfg_period = '0; ch_en = '0;
    o_valid = 1'b0; o_ch = '0; o_period = '0; o_en = '0;
    step();
    step();
    check_eq("rst_tick", 32'(tick), 32'(0));
    check_eq("rst_slow", 32'(slow), 32'(0));
    check_eq("rst_busy", 32'(busy), 32'(0));
    check_eq("rst_ready", 32'(cfg_ready), 32'(1));
    rst_ni = 1'b1;
    step();

    // Program ch0 to P=4 while disabled, then enable.
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd4;
    step();
    cfg_valid = 1'b0;
    check_eq("t1_busy", 32'(busy), 32'(0));
    ch_en = 4'b0001;
    exp_slow = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k % 4 == 0) exp_slow = ~exp_slow;
      check_eq("t1_tick", 32'(tick), (k % 4 == 0) ? 32'(1) : 32'(0));
      check_eq("t1_slow", 32'(slow), 32'({3'b000, exp_slow}));
    end

    // ch0 at P=10, write P=3 when cnt=5: this period stays 10, then 3.
    ch_en = 4'b0000;
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_period = 16'd10;
    step();
    cfg_valid = 1'b0;
    check_eq("t2_slow_hold", 32'(slow[0]), 32'(1));
    ch_en = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_t = (k == 10) || (k == 13) || (k == 16);
      exp_b = (k >= 5) && (k <= 9);
      if (exp_t) exp_slow = ~exp_slow;
      check_eq("t2_tick", 32'(tick), 32'({3'b000, exp_t}));
      check_eq("t2_slow", 32'(slow[0]), 32'(exp_slow));
      check_eq("t2_busy", 32'(busy), 32'(exp_b));
      check_eq("t2_ready", 32'(cfg_ready), 32'(!exp_b));
      if (k == 4) begin cfg_valid = 1'b1; cfg_period = 16'd3; end
      if (k == 5) cfg_valid = 1'b0;
    end

    // P=0 written to disabled ch1 behaves as P=1.
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_period = 16'd0;
    step();
    cfg_valid = 1'b0;
    ch_en = 4'b0010;
    for (int k = 1; k <= 4; k++) begin
      step();
      check_eq("t3_tick", 32'(tick), 32'(4'b0010));
      check_eq("t3_slow", 32'(slow[1]), 32'(k % 2));
    end

    // ch2 at P=8; write P=2 on the boundary edge, then a stalled second write of P=5.
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_period = 16'd8;
    step();
    cfg_valid = 1'b0;
    ch_en = 4'b0100;
    for (int k = 1; k <= 23; k++) begin
      step();
      exp_t = (k == 8) || (k == 16) || (k == 18) || (k == 23);
      exp_b = ((k >= 8) && (k <= 15)) || (k == 17);
      check_eq("t4_tick", 32'(tick), exp_t ? 32'(4) : 32'(0));
      check_eq("t4_busy", 32'(busy), 32'(exp_b));
      check_eq("t4_ready", 32'(cfg_ready), 32'(!exp_b));
      if (k == 7) begin cfg_valid = 1'b1; cfg_period = 16'd2; end
      if (k == 8) cfg_period = 16'd5;
      if (k == 17) cfg_valid = 1'b0;
    end

    // Four channels P=2,3,5,7 from a clean reset: all coincide first at 210.
    ch_en = 4'b0000;
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cfg_valid = 1'b1; cfg_ch = 2'(c); cfg_period = 16'(per[c]);
      step();
    end
    cfg_valid = 1'b0;
    ch_en = 4'b1111;
    first_all = 0;
    for (int k = 1; k <= 210; k++) begin
      step();
      exp_v = {k % 7 == 0, k % 5 == 0, k % 3 == 0, k % 2 == 0};
      check_eq("t5_tick", 32'(tick), 32'(exp_v));
      if (tick == 4'hf && first_all == 0) first_all = k;
    end
    check_eq("t5_first_all", first_all, 32'(210));
    check_eq("t5_slow", 32'(slow), 32'(4'b0001));

    // Deferred write on ch3, then async reset mid-cycle.
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_period = 16'd4;
    step();
    cfg_valid = 1'b0;
    step();
    step();
    check_eq("t6_busy_pre", 32'(busy), 32'(1));
    check_eq("t6_tick_pre", 32'(tick), 32'(4'b0010));
    check_eq("t6_slow_pre", 32'(slow), 32'(4'b0010));
    #2 rst_ni = 1'b0;
    #1;
    check_eq("t6_tick_rst", 32'(tick), 32'(0));
    check_eq("t6_slow_rst", 32'(slow), 32'(0));
    check_eq("t6_busy_rst", 32'(busy), 32'(0));
    check_eq("t6_ready_rst", 32'(cfg_ready), 32'(1));
    #1 rst_ni = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check_eq("t6_tick_def", 32'(tick), (k == 6) ? 32'(4'hf) : 32'(0));
      check_eq("t6_busy_def", 32'(busy), 32'(0));
    end

    // 5-channel instance: cfg_ch=7 is accepted and discarded.
    o_ch = 3'd7;
    #1;
    check_eq("oor_ready", 32'(o_ready), 32'(1));
    o_valid = 1'b1; o_period = 8'd1;
    step();
    o_valid = 1'b0;
    check_eq("oor_busy", 32'(o_busy), 32'(0));
    o_en = 5'h1f;
    for (int k = 1; k <= 3; k++) begin
      step();
      check_eq("oor_tick", 32'(o_tick), (k == 3) ? 32'(5'h1f) : 32'(0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
